// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator scheduler.
package elevator_pkg;

    localparam int unsigned FLOORS_DEF     = 4;
    localparam int unsigned MOVE_TICKS_DEF = 50_000_000;
    localparam int unsigned DOOR_TICKS_DEF = 100_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } elev_state_t;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Call/status bundle between the floor buttons, display/motor logic and the scheduler.
// Optional door_hold input is present when ELEV_DOOR_HOLD_EN is defined.
interface elevator_scheduler_if
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS = FLOORS_DEF
) ();

    localparam int unsigned FW = (FLOORS > 2) ? $clog2(FLOORS) : 1;

    logic [FLOORS-1:0] req_press;
    logic [FLOORS-1:0] req_pending;
    logic [FW-1:0]     cur_floor;
    logic              dir_up;
    logic              moving;
    logic              door_open;
    logic              arrive;
`ifdef ELEV_DOOR_HOLD_EN
    logic              door_hold;
`endif

    modport master (
`ifdef ELEV_DOOR_HOLD_EN
        output door_hold,
`endif
        output req_press,
        input  req_pending, cur_floor, dir_up, moving, door_open, arrive
    );

    modport slave (
`ifdef ELEV_DOOR_HOLD_EN
        input  door_hold,
`endif
        input  req_press,
        output req_pending, cur_floor, dir_up, moving, door_open, arrive
    );

endinterface

// File: rtl/elev_tick_timer.sv
// Clear/enable cycle counter 0..TICKS-1 with a terminal-count flag.
module elev_tick_timer #(
    parameter int unsigned TICKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned W = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] cnt;

    // Counter: clear wins over enable; wraps to 0 on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tc_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-policy elevator scheduler: latches calls, sequences move and door phases.
// Optional feature: ELEV_DOOR_HOLD_EN adds a door_hold input that freezes the door timer.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS     = FLOORS_DEF,
    parameter int unsigned MOVE_TICKS = MOVE_TICKS_DEF,
    parameter int unsigned DOOR_TICKS = DOOR_TICKS_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    elevator_scheduler_if.slave bus
);

    localparam int unsigned FW = (FLOORS > 2) ? $clog2(FLOORS) : 1;
    localparam logic [FW-1:0]     TOP = FW'(FLOORS - 1);
    localparam logic [FLOORS-1:0] ONE = FLOORS'(1);

    elev_state_t       state, state_nx;
    logic [FLOORS-1:0] pending, pending_nx;
    logic [FW-1:0]     floor_q, floor_nx;
    logic              dir_q, dir_nx;
    logic              arrive_q, arrive_nx;

    logic              moving_c, door_c;
    logic              move_tc_c, door_tc_c, door_clr_c, hold_c;
    logic [FLOORS-1:0] above_c, below_c, press_c, clear_c;
    logic [FW-1:0]     nf_c;
    logic              beyond_c;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold_c = bus.door_hold;
`else
    assign hold_c = 1'b0;
`endif

    assign moving_c   = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_c     = (state == DOOR_OPEN);
    // Same-floor press or hold while open restarts the door countdown.
    assign door_clr_c = !door_c || hold_c || bus.req_press[floor_q];

    elev_tick_timer #(.TICKS(MOVE_TICKS)) u_move_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!moving_c),
        .en   (moving_c),
        .tc_c (move_tc_c)
    );

    elev_tick_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (door_clr_c),
        .en   (door_c),
        .tc_c (door_tc_c)
    );

    // Pending calls strictly above / below the current floor.
    always_comb begin
        above_c = '0;
        below_c = '0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            above_c[i] = pending[i] && (i > int'(floor_q));
            below_c[i] = pending[i] && (i < int'(floor_q));
        end
    end

    // Next-state, floor stepping and call latch/clear.
    always_comb begin
        state_nx  = state;
        floor_nx  = floor_q;
        dir_nx    = dir_q;
        arrive_nx = 1'b0;
        clear_c   = '0;
        nf_c      = floor_q;
        beyond_c  = 1'b0;
        press_c   = bus.req_press & ~(door_c ? (ONE << floor_q) : '0);

        case (state)
            IDLE: begin
                if (pending[floor_q]) begin
                    state_nx = DOOR_OPEN;
                    clear_c  = ONE << floor_q;
                end else if ((|above_c) && (dir_q || !(|below_c))) begin
                    state_nx = MOVE_UP;
                    dir_nx   = 1'b1;
                end else if (|below_c) begin
                    state_nx = MOVE_DOWN;
                    dir_nx   = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (move_tc_c) begin
                    if (state == MOVE_UP) begin
                        nf_c = (floor_q == TOP) ? floor_q : floor_q + FW'(1);
                    end else begin
                        nf_c = (floor_q == '0) ? floor_q : floor_q - FW'(1);
                    end
                    for (int i = 0; i < int'(FLOORS); i++) begin
                        if (pending[i] && ((state == MOVE_UP) ? (i > int'(nf_c)) : (i < int'(nf_c)))) begin
                            beyond_c = 1'b1;
                        end
                    end
                    floor_nx  = nf_c;
                    arrive_nx = 1'b1;
                    if (pending[nf_c]) begin
                        state_nx = DOOR_OPEN;
                        clear_c  = ONE << nf_c;
                    end else if (!beyond_c) begin
                        state_nx = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                clear_c = ONE << floor_q;
                if (door_tc_c) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        pending_nx = (pending | press_c) & ~clear_c;
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            arrive_q <= 1'b0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            floor_q  <= floor_nx;
            dir_q    <= dir_nx;
            arrive_q <= arrive_nx;
        end
    end

    assign bus.req_pending = pending;
    assign bus.cur_floor   = floor_q;
    assign bus.dir_up      = dir_q;
    assign bus.moving      = moving_c;
    assign bus.door_open   = door_c;
    assign bus.arrive      = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with MOVE_TICKS=4, DOOR_TICKS=6.
module tb_elevator_scheduler;

    logic clk;
    logic rst_n;

    elevator_scheduler_if #(.FLOORS(4)) bus ();

    elevator_scheduler #(
        .FLOORS    (4),
        .MOVE_TICKS(4),
        .DOOR_TICKS(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Press applied before an edge and outputs expected after it.
    typedef struct packed {
        logic [3:0] press;
        logic [3:0] pend;
        logic [1:0] floor;
        logic       dir;
        logic       mov;
        logic       door;
        logic       arr;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [9:0] outs();
        return {bus.req_pending, bus.cur_floor, bus.dir_up, bus.moving, bus.door_open, bus.arrive};
    endfunction

    function automatic vec_t mk(input logic [3:0] p, input logic [3:0] pe, input logic [1:0] f,
                                input logic d, input logic m, input logic o, input logic a);
        vec_t v;
        v = '{p, pe, f, d, m, o, a};
        return v;
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.req_press = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [3:0] mask);
        bus.req_press = mask;
        @(negedge clk);
        bus.req_press = '0;
    endtask

    task automatic wait_arrive(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arrive && n < 60);
        check(name, 32'(bus.arrive), 32'd1);
    endtask

    task automatic wait_moving(input string name);
        int n;
        n = 0;
        while (!bus.moving && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.moving), 32'd1);
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17];
        int   dc;
        int   n;
        logic done;

`ifdef ELEV_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        // Single call to floor 2 from floor 0.
        tbl[0]  = mk(4'b0100, 4'b0100, 2'd0, 1, 0, 0, 0);
        tbl[1]  = mk(4'b0000, 4'b0100, 2'd0, 1, 1, 0, 0);
        tbl[2]  = mk(4'b0000, 4'b0100, 2'd0, 1, 1, 0, 0);
        tbl[3]  = mk(4'b0000, 4'b0100, 2'd0, 1, 1, 0, 0);
        tbl[4]  = mk(4'b0000, 4'b0100, 2'd0, 1, 1, 0, 0);
        tbl[5]  = mk(4'b0000, 4'b0100, 2'd1, 1, 1, 0, 1);
        tbl[6]  = mk(4'b0000, 4'b0100, 2'd1, 1, 1, 0, 0);
        tbl[7]  = mk(4'b0000, 4'b0100, 2'd1, 1, 1, 0, 0);
        tbl[8]  = mk(4'b0000, 4'b0100, 2'd1, 1, 1, 0, 0);
        tbl[9]  = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 1, 1);
        tbl[10] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 1, 0);
        tbl[11] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 1, 0);
        tbl[12] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 1, 0);
        tbl[13] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 1, 0);
        tbl[14] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 1, 0);
        tbl[15] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 0, 0);
        tbl[16] = mk(4'b0000, 4'b0000, 2'd2, 1, 0, 0, 0);

        rst_n = 1'b0;
        bus.req_press = '0;
        @(negedge clk);
        reset_dut();
        check("reset_state", 32'(outs()), 32'(10'b0000_00_1_0_0_0));

        // Table-driven single call up.
        for (int i = 0; i < 17; i++) begin
            bus.req_press = tbl[i].press;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t1_row%0d", i), 32'(outs()), 32'(tbl[i][9:0]));
        end
        bus.req_press = '0;

        // LOOK ordering: pass floor 2, serve 3, then reverse to 0.
        reset_dut();
        press(4'b1000);
        wait_arrive("t2_arr1");
        check("t2_floor1", 32'(bus.cur_floor), 32'd1);
        press(4'b0001);
        check("t2_pending", 32'(bus.req_pending), 32'b1001);
        wait_arrive("t2_arr2");
        check("t2_pass2", 32'({bus.cur_floor, bus.moving, bus.door_open}), 32'({2'd2, 1'b1, 1'b0}));
        wait_arrive("t2_arr3");
        check("t2_serve3", 32'({bus.cur_floor, bus.door_open, bus.dir_up, bus.req_pending}),
              32'({2'd3, 1'b1, 1'b1, 4'b0001}));
        wait_moving("t2_reverse");
        check("t2_dir_down", 32'({bus.dir_up, bus.cur_floor}), 32'({1'b0, 2'd3}));
        wait_arrive("t2_arr4");
        wait_arrive("t2_arr5");
        check("t2_floor1_down", 32'({bus.cur_floor, bus.moving}), 32'({2'd1, 1'b1}));
        wait_arrive("t2_arr6");
        check("t2_serve0", 32'({bus.cur_floor, bus.door_open, bus.req_pending}), 32'({2'd0, 1'b1, 4'b0000}));

        // Entry-edge press loses to clear; same-floor press restarts the door.
        reset_dut();
        bus.req_press = 4'b0001;
        @(negedge clk);
        check("t3_latch", 32'(bus.req_pending), 32'b0001);
        @(negedge clk);
        bus.req_press = '0;
        check("t3_entry_clear", 32'({bus.req_pending, bus.door_open}), 32'({4'b0000, 1'b1}));
        dc = 1;
        done = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            bus.req_press = '0;
            if (!bus.door_open) break;
            dc++;
            if (done && dc == 4) check("t3_no_latch", 32'(bus.req_pending), 32'd0);
            if (dc == 3 && !done) begin
                bus.req_press = 4'b0001;
                done = 1'b1;
            end
        end
        check("t3_door_cycles", 32'(dc), 32'd9);
        check("t3_after", 32'(outs()), 32'(10'b0000_00_1_0_0_0));

        // All four floors called at once.
        press(4'b1111);
        check("t4_latch", 32'(bus.req_pending), 32'b1111);
        @(negedge clk);
        check("t4_door0", 32'({bus.cur_floor, bus.door_open, bus.req_pending}), 32'({2'd0, 1'b1, 4'b1110}));
        wait_arrive("t4_arr1");
        check("t4_door1", 32'({bus.cur_floor, bus.door_open}), 32'({2'd1, 1'b1}));
        wait_arrive("t4_arr2");
        check("t4_door2", 32'({bus.cur_floor, bus.door_open}), 32'({2'd2, 1'b1}));
        wait_arrive("t4_arr3");
        check("t4_door3", 32'({bus.cur_floor, bus.door_open, bus.req_pending}), 32'({2'd3, 1'b1, 4'b0000}));

        // Asynchronous reset in the middle of a move.
        reset_dut();
        press(4'b0100);
        wait_arrive("t5_arr1");
        #2 rst_n = 1'b0;
        #1 check("t5_async", 32'(outs()), 32'(10'b0000_00_1_0_0_0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_idle", 32'(outs()), 32'(10'b0000_00_1_0_0_0));

`ifdef ELEV_DOOR_HOLD_EN
        // Door held open for 10 cycles, then closes DOOR_TICKS cycles after release.
        reset_dut();
        press(4'b0001);
        @(negedge clk);
        check("t6_open", 32'(bus.door_open), 32'd1);
        bus.door_hold = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_held", 32'(bus.door_open), 32'd1);
        bus.door_hold = 1'b0;
        dc = 0;
        n = 0;
        while (bus.door_open && n < 40) begin
            dc++;
            n++;
            @(negedge clk);
        end
        check("t6_release_cycles", 32'(dc), 32'd6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

- Schedules the elevator car among floor call buttons using a directional LOOK policy.
- Inputs are one-cycle press pulses from the per-floor debouncers, which are fed straight into `req_press`.
- The block latches the calls and sequences the car through move and door-open phases using cycle-count timers.
- It drives the floor, direction and door status consumed by the display and motor logic.

## Interface
- `FLOORS`, 4: number of floors (≥2); floors are numbered 0..FLOORS-1.
- `MOVE_TICKS`, 50_000_000: clock cycles of travel per floor (≥2).
- `DOOR_TICKS`, 100_000_000: clock cycles the door stays open (≥2).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `req_press` in FLOORS: one-cycle call pulse per floor, one bit per floor; several bits may pulse together.
- `req_pending` out FLOORS: latched outstanding calls.
- `cur_floor` out $clog2(FLOORS): floor the car is at or last passed.
- `dir_up` out 1: remembered travel direction; 1 means up.
- `moving` out 1: high in MOVE_UP or MOVE_DOWN.
- `door_open` out 1: high in DOOR_OPEN.
- `arrive` out 1: one-cycle pulse when `cur_floor` changes.

## Operation
- **States:** IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- **Reset values:** state IDLE; `req_pending`=0, `cur_floor`=0, `dir_up`=1, `moving`=0, `door_open`=0, `arrive`=0; both timers 0.
- **Latching:** a `req_press` bit sets the matching `req_pending` bit, except for `cur_floor` while in DOOR_OPEN. In that case the press is not latched and the door timer restarts at 0.
- **IDLE priority, highest first:**
  1. `req_pending[cur_floor]` → DOOR_OPEN.
  2. A call above, and either `dir_up`=1 or no call below → MOVE_UP, with `dir_up`=1.
  3. A call below → MOVE_DOWN, with `dir_up`=0.
  4. Otherwise stay in IDLE.
- **MOVE_x:**
  - The move timer counts 0..MOVE_TICKS-1.
  - At terminal count, `cur_floor` steps ±1, `arrive` pulses and the timer clears.
  - Stop decision uses the new floor `nf`:
    - `req_pending[nf]` → DOOR_OPEN.
    - Otherwise, any call strictly beyond `nf` in the travel direction → stay in the same state.
    - Otherwise → IDLE.
- **Floor bounds:** the car never steps below 0 or above FLOORS-1. A move is only entered when a call exists in that direction, so the bounds are never reached with a pending step.
- **DOOR_OPEN:**
  - On entry, `req_pending[cur_floor]` clears; it is held clear for the whole state.
  - The door timer counts 0..DOOR_TICKS-1, then the state returns to IDLE.
- **Simultaneous set and clear:** on the DOOR_OPEN entry edge, a press for `cur_floor` loses to the clear. Presses for other floors always latch.
- **Reset mid-operation:** everything returns to reset values immediately; all pending calls are lost.
- **Timer widths:** $clog2 of the respective TICKS parameter; timers never wrap past terminal count.

## Timing
- **Call latency:**
  - A pulse sampled at edge E appears on `req_pending` after E.
  - The IDLE decision happens at edge E+1.
  - `moving` or `door_open` rises after E+1.
- **Travel:** MOVE is entered at edge S; `arrive` and the new `cur_floor` appear after edge S+MOVE_TICKS.
- **Door:** DOOR_OPEN is entered at edge D and is left at edge D+DOOR_TICKS, absent restarts.
- **Registered outputs:** all outputs are registers or decodes of the state register; there is no combinational path from `req_press` to any output.

## Configuration
- **Macro:** `ELEV_DOOR_HOLD_EN`.
- **Defined:** adds input `door_hold`, 1 bit.
  - While `door_hold`=1 in DOOR_OPEN, the door timer is held at 0.
  - Counting resumes after release, so the door closes DOOR_TICKS cycles after release.
  - `door_hold` has no effect in other states.
- **Undefined:** the port is absent and DOOR_OPEN lasts exactly DOOR_TICKS cycles, apart from same-floor press restarts.

## Structure
- **Package `elevator_pkg`:** state enum `elev_state_t` with IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN, plus default constants for FLOORS, MOVE_TICKS and DOOR_TICKS.
- **Sub-module `elev_tick_timer`:** a parameterised clear/enable counter with a terminal-count flag. It is instantiated twice, once for move and once for door.
- **Top level:** the LOOK decision logic (above/below masks relative to `cur_floor`) lives in the top-level module.

## Test plan
Use MOVE_TICKS=4 and DOOR_TICKS=6 throughout.
1. **Single call up:** idle at 0, pulse `req_press`=4'b0100 → two `arrive` pulses 4 cycles apart, then `cur_floor`=2 and `door_open` high for 6 cycles; `req_pending` ends at 0.
2. **LOOK ordering:** at floor 1 moving up, calls at 3 and 0 latch → stop at 2? No, pass 2, serve 3, return to IDLE, then move down to 0. `dir_up` goes 1 then 0.
3. **Same-floor press in DOOR_OPEN:** press `cur_floor` at door cycle 3 → `req_pending` stays 0 and door stays open 6 more cycles, 9 in total.
4. **Simultaneous calls:** idle at 0, `req_press`=4'b1111 → door opens at 0, then stops at 1, 2 and 3 in order; the final `cur_floor` is 3.
5. **Async reset:** assert `rst_n`=0 mid-MOVE_UP → all outputs return to reset values without waiting for a clock edge; after release the block stays in IDLE with no calls.
6. **Door hold (with `ELEV_DOOR_HOLD_EN`):** hold `door_hold`=1 for 10 cycles in DOOR_OPEN → the door closes 6 cycles after release.
